// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// F stage of the five-stage MIPS pipeline. It owns the fetch PC, issues
// instruction-memory reads over a req/ack handshake, and drives the F/D
// pipeline register for the decode stage. When an instruction comes back
// while the pipeline is stalled, a one-entry hold buffer keeps it. It is
// then delivered once the stall clears, without re-fetching the same PC.
//
// Optional feature macro: FETCH_ADEL_EN
//   When defined, a misaligned or out-of-range fetch PC is not requested.
//   It completes at once with instruction 0 and D_excode = 4 (AdEL).
//   When undefined, every PC is requested and D_excode stays 0.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   IM_BASE   lowest legal instruction address (AdEL check only)
//   IM_WORDS  instruction memory size in words (AdEL check only)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   npc_pc       next fetch address computed by the NPC from F_pc
//   stall        hazard stall; hold F_pc and the F/D register
//   flush_d      load a bubble into the F/D register
//   F_pc         current fetch PC
//   im_req       instruction read request
//   im_addr      instruction read address (same as F_pc)
//   im_ack       read data valid; may arrive in the same cycle as im_req
//   im_rdata     instruction word, valid with im_ack
//   fetch_busy   a fetch is outstanding
//   D_pc         F/D register: PC
//   D_instr      F/D register: instruction
//   D_valid      F/D register: valid
//   D_excode     F/D register: fetch exception code
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_pc,
  input  logic        stall,
  input  logic        flush_d,
  output logic [31:0] F_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        fetch_busy,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic [4:0]  D_excode
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef FETCH_ADEL_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif

  // One past the last legal instruction byte. It is 33 bits wide so the
  // range test cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [0:0]  state_q,      state_d;
  logic [31:0] f_pc_q,       f_pc_d;
  logic [31:0] d_pc_q,       d_pc_d;
  logic [31:0] d_instr_q,    d_instr_d;
  logic        d_valid_q,    d_valid_d;
  logic [4:0]  d_excode_q,   d_excode_d;
  logic [31:0] hold_pc_q,    hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [4:0]  hold_exc_q,   hold_exc_d;

  logic        pc_bad;
  logic        ack_eff;
  logic [31:0] data_eff;
  logic [4:0]  exc_eff;
  logic        load;
  logic [31:0] ld_pc;
  logic [31:0] ld_instr;
  logic [4:0]  ld_exc;

  // The range check is always built. In the default build it is masked off
  // by ADEL_EN, so it folds away.
  always_comb begin
    pc_bad = ADEL_EN &&
             ((f_pc_q[1:0] != 2'b00) ||
              (f_pc_q < IM_BASE) ||
              ({1'b0, f_pc_q} >= IM_END));
  end

  // An illegal PC behaves exactly like a completed read that returned 0.
  always_comb begin
    ack_eff  = pc_bad || im_ack;
    data_eff = pc_bad ? 32'd0 : im_rdata;
    exc_eff  = pc_bad ? EXC_ADEL : EXC_NONE;
  end

  always_comb begin
    state_d      = state_q;
    f_pc_d       = f_pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_exc_d   = hold_exc_q;
    load         = 1'b0;
    ld_pc        = d_pc_q;
    ld_instr     = d_instr_q;
    ld_exc       = d_excode_q;

    case (state_q)
      ST_REQ: begin
        if (ack_eff) begin
          if (!stall) begin
            load     = 1'b1;
            ld_pc    = f_pc_q;
            ld_instr = data_eff;
            ld_exc   = exc_eff;
            f_pc_d   = npc_pc;
          end else begin
            // Park the word so the PC is not fetched again after the stall.
            hold_pc_d    = f_pc_q;
            hold_instr_d = data_eff;
            hold_exc_d   = exc_eff;
            state_d      = ST_HOLD;
          end
        end
      end
      default: begin
        if (!stall) begin
          load     = 1'b1;
          ld_pc    = hold_pc_q;
          ld_instr = hold_instr_q;
          ld_exc   = hold_exc_q;
          f_pc_d   = npc_pc;
          state_d  = ST_REQ;
        end
      end
    endcase
  end

  // F/D register. A flush turns this cycle's content into a bubble, but the
  // PC still advances as usual. A stall overrides the flush.
  always_comb begin
    d_pc_d     = d_pc_q;
    d_instr_d  = d_instr_q;
    d_valid_d  = d_valid_q;
    d_excode_d = d_excode_q;
    if (!stall) begin
      if (load) begin
        d_pc_d     = ld_pc;
        d_instr_d  = ld_instr;
        d_valid_d  = 1'b1;
        d_excode_d = ld_exc;
      end
      if (flush_d) begin
        d_instr_d  = 32'd0;
        d_valid_d  = 1'b0;
        d_excode_d = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_REQ;
      f_pc_q       <= RESET_PC;
      d_pc_q       <= 32'd0;
      d_instr_q    <= 32'd0;
      d_valid_q    <= 1'b0;
      d_excode_q   <= EXC_NONE;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_exc_q   <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      f_pc_q       <= f_pc_d;
      d_pc_q       <= d_pc_d;
      d_instr_q    <= d_instr_d;
      d_valid_q    <= d_valid_d;
      d_excode_q   <= d_excode_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_exc_q   <= hold_exc_d;
    end
  end

  assign F_pc       = f_pc_q;
  assign im_addr    = f_pc_q;
  assign im_req     = (state_q == ST_REQ) && !pc_bad;
  assign fetch_busy = (state_q == ST_REQ) && !ack_eff;
  assign D_pc       = d_pc_q;
  assign D_instr    = d_instr_q;
  assign D_valid    = d_valid_q;
  assign D_excode   = d_excode_q;

endmodule
